// File: rtl/wb_pkg.sv
// Shared definitions for the writeback stage: load size encodings and the
// MEM/WB pipeline register layout.
package wb_pkg;

  localparam int DEF_XLEN = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Fields captured from MEM; alu_out is sized by the package default width.
  typedef struct packed {
    logic                valid;
    logic [31:0]         pc;
    logic [DEF_XLEN-1:0] alu_out;
    logic [4:0]          rd_addr;
    logic [2:0]          funct3;
    logic                mem_to_reg;
    logic                reg_write;
    logic                freg_write;
  } mem_wb_t;

endpackage

// File: rtl/load_aligner.sv
// Selects the byte/halfword addressed by off from a memory word and
// sign- or zero-extends it according to the load funct3.
module load_aligner
  import wb_pkg::*;
#(
  parameter int XLEN = DEF_XLEN
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      off,
  input  logic [XLEN-1:0] word,
  output logic [XLEN-1:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[7:0];
    case (off)
      2'd0: byte_sel = word[7:0];
      2'd1: byte_sel = word[15:8];
      2'd2: byte_sel = word[23:16];
      2'd3: byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase
    // off=3 halfword is misaligned; it takes the upper half without trapping.
    half_sel = off[1] ? word[31:16] : word[15:0];

    data = word;
    case (funct3)
      F3_LB:  data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LH:  data = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_LW:  data = word;
      F3_LBU: data = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LHU: data = {{(XLEN-16){1'b0}}, half_sel};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB register, load alignment, single-pulse register
// file write enables and the retired-instruction counter.
module wb_stage
  import wb_pkg::*;
#(
  parameter int XLEN      = DEF_XLEN,
  parameter int INSTRET_W = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 MEM_stall,
  input  logic                 MEM_valid,
  input  logic [31:0]          MEM_pc_out,
  input  logic [XLEN-1:0]      MEM_alu_out,
  input  logic [4:0]           MEM_rd_addr,
  input  logic [2:0]           MEM_funct3,
  input  logic                 MEM_MemtoReg,
  input  logic                 MEM_RegWrite,
  input  logic                 MEM_FRegWrite,
  input  logic [XLEN-1:0]      DM_dout,
  output logic [XLEN-1:0]      WB_rd_data,
  output logic [4:0]           WB_rd_addr,
  output logic                 WB_RegWrite,
  output logic                 WB_FRegWrite,
  output logic                 WB_valid,
  output logic [31:0]          WB_pc_out,
  output logic [INSTRET_W-1:0] WB_instret
);

  mem_wb_t                wb_q;
  mem_wb_t                mem_d;
  logic                   wr_done;
  logic [XLEN-1:0]        ld_hold;
  logic [XLEN-1:0]        ld_data;
  logic [INSTRET_W-1:0]   instret_q;
  logic                   fire;

  always_comb begin
    mem_d            = '0;
    mem_d.valid      = MEM_valid;
    mem_d.pc         = MEM_pc_out;
    mem_d.alu_out    = MEM_alu_out;
    mem_d.rd_addr    = MEM_rd_addr;
    mem_d.funct3     = MEM_funct3;
    mem_d.mem_to_reg = MEM_MemtoReg;
    mem_d.reg_write  = MEM_RegWrite;
    mem_d.freg_write = MEM_FRegWrite;
  end

  load_aligner #(.XLEN(XLEN)) u_align (
    .funct3 (wb_q.funct3),
    .off    (wb_q.alu_out[1:0]),
    .word   (DM_dout),
    .data   (ld_data)
  );

  // wr_done marks that the resident instruction already had its one write cycle.
  assign fire = wb_q.valid & ~wr_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_q      <= '0;
      wr_done   <= 1'b1;
      ld_hold   <= '0;
      instret_q <= '0;
    end else begin
      if (!MEM_stall) begin
        wb_q    <= mem_d;
        wr_done <= 1'b0;
      end else begin
        wr_done <= 1'b1;
      end
      // DM_dout is only valid in the first WB cycle, so keep a copy for stalls.
      if (fire && wb_q.mem_to_reg) ld_hold <= ld_data;
      if (fire) instret_q <= instret_q + 1'b1;
    end
  end

  assign WB_RegWrite  = fire & wb_q.reg_write & (wb_q.rd_addr != 5'd0);
  assign WB_FRegWrite = fire & wb_q.freg_write;
  assign WB_rd_data   = wb_q.mem_to_reg ? (wr_done ? ld_hold : ld_data) : wb_q.alu_out;
  assign WB_rd_addr   = wb_q.rd_addr;
  assign WB_valid     = wb_q.valid;
  assign WB_pc_out    = wb_q.pc;
  assign WB_instret   = instret_q;

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
Writeback stage. It is the producer side of the register-file write port that the decode stage consumes: WB_rd_data, WB_rd_addr, WB_RegWrite and WB_FRegWrite.
- Holds the MEM/WB pipeline register.
- Aligns and sign/zero-extends load data from the synchronous data memory.
- Issues exactly one write-enable pulse per retired instruction, even across stalls.
- Keeps a retired-instruction counter.

Parameters:
XLEN, 32, datapath and register-file data width
INSTRET_W, 64, width of retired-instruction counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
MEM_stall  in  1  pipeline hold; WB register keeps its contents
MEM_valid  in  1  MEM stage carries a real instruction (0 = bubble)
MEM_pc_out  in  32  PC of MEM instruction
MEM_alu_out  in  32  ALU result / load address / link value
MEM_rd_addr  in  5  destination register
MEM_funct3  in  3  load size/sign encoding
MEM_MemtoReg  in  1  result comes from data memory
MEM_RegWrite  in  1  integer register-file write
MEM_FRegWrite  in  1  floating register-file write
DM_dout  in  32  data-memory read word; valid only in the first cycle an instruction occupies WB
WB_rd_data  out  32  write data to register files
WB_rd_addr  out  5  write address
WB_RegWrite  out  1  integer write enable (one-cycle pulse)
WB_FRegWrite  out  1  float write enable (one-cycle pulse)
WB_valid  out  1  WB holds a valid instruction
WB_pc_out  out  32  PC of WB instruction (debug/trace)
WB_instret  out  64  retired-instruction count

Behaviour:
- Reset (rst=0, asynchronous): clear all state registers. Resulting outputs: WB_rd_data 0, WB_rd_addr 0, WB_RegWrite 0, WB_FRegWrite 0, WB_valid 0, WB_pc_out 0, WB_instret 0. Internal wr_done=1 and ld_hold=0. Any pending write is discarded; nothing is written after rst rises.
- Pipeline register, on posedge clk:
  - MEM_stall=0: capture all MEM_* fields; valid<=MEM_valid; wr_done<=0.
  - MEM_stall=1: hold all fields; wr_done<=1.
- Writeback cycle: the first cycle after capture, i.e. wr_done=0.
  - fire = valid & ~wr_done.
  - WB_RegWrite = fire & RegWrite & (rd_addr != 0). x0 is never written.
  - WB_FRegWrite = fire & FRegWrite. f0 is writable.
  - Each instruction pulses at most once, however long it stays stalled in WB.
- Load capture:
  - When fire & MemtoReg, register the aligned DM_dout into ld_hold.
  - WB_rd_data = MemtoReg ? (wr_done ? ld_hold : aligned DM_dout) : alu_out.
  - Output data therefore stays stable through stalls even if DM_dout changes.
- Alignment, with off = alu_out[1:0]:
  - 000 LB: sign-extend byte at off.
  - 001 LH: sign-extend half selected by off[1].
  - 010 LW/FLW: word.
  - 100 LBU: zero-extend byte at off.
  - 101 LHU: zero-extend half selected by off[1].
  - Other encodings: raw word.
  - Misaligned halfword (off=3) uses the upper half; no trap is raised.
- Non-load results: alu_out passes through unchanged; link/PC+4 selection is done upstream.
- WB_instret:
  - Increments by 1 when fire=1, whether or not a write occurs (stores and branches count).
  - Bubbles never count.
  - Wraps from 2^64-1 to 0.
- Simultaneous events:
  - A stall asserted in the writeback cycle still lets that cycle's write and count happen.
  - Bubble (MEM_valid=0) with MEM_RegWrite=1 produces no write and no count.
- Latency: MEM to register-file write is 1 cycle; combinational from the WB register plus DM_dout.

Decomposition:
- Package wb_pkg:
  - Load funct3 constants: F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU.
  - XLEN default.
  - Typedef mem_wb_t: packed struct of the captured MEM fields.
- Sub-module load_aligner: combinational; inputs funct3, off, word; output XLEN data. Reusable by a future store/load unit.

Test Plan:
- Reset: drive rst=0 mid-stream with MEM_RegWrite=1 -> all outputs 0, WB_instret=0; no write pulse after rst rises until a new valid instruction arrives.
- ALU write: MEM_valid=1, RegWrite=1, rd=5, alu_out=0x1234_5678 -> next cycle WB_RegWrite=1 for exactly 1 cycle, WB_rd_addr=5, WB_rd_data=0x12345678, instret +1.
- x0/f0: rd=0 with RegWrite -> WB_RegWrite stays 0, instret +1. rd=0 with FRegWrite -> WB_FRegWrite=1.
- Loads, DM_dout=0x80FF_7F01:
  - LB off=3 -> 0xFFFFFF80.
  - LBU off=1 -> 0x0000007F.
  - LH off=2 -> 0xFFFF80FF.
  - LHU off=0 -> 0x00007F01.
  - LW -> 0x80FF7F01.
- Stall hold: LW load, then MEM_stall=1 for 3 cycles while DM_dout changes to 0xDEADBEEF -> one write pulse only; WB_rd_data stays at the original word all 3 cycles; instret +1 total.
- Bubble and wrap: MEM_valid=0 with RegWrite=1 -> no pulse, no count. Preload the counter to 2^64-1 (force) and retire one instruction -> WB_instret=0.
